// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of N_CH first-word-fall-through FIFOs onto a single
// registered valid/ready stream, with grants capped at BURST_LEN beats.
package fifo_drain_arbiter_pkg;
  typedef struct packed {
    logic        pop;
    logic        push;
    logic        flush;
    logic [31:0] data;
  } fifo_req_t;

  typedef struct packed {
    logic        empty;
    logic        full;
    logic        alm_full;
    logic [31:0] data;
  } fifo_resp_t;
endpackage

module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned BURST_LEN = 8,
  localparam int unsigned CH_W      = $clog2(N_CH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N_CH-1:0] flush_i,
  output fifo_req_t       fifo_req_o [N_CH],
  input  fifo_resp_t      fifo_resp_i [N_CH],
  output logic [31:0]     data_o,
  output logic [CH_W-1:0] ch_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            busy_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] gnt_ch, gnt_ch_nxt;
  logic [CH_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [7:0]      beat_cnt, beat_cnt_nxt;
  logic [N_CH-1:0] avail;
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] pick;
  logic            found;
  logic            slot_free;
  logic            pop_any;
  logic            unused_resp;

  assign slot_free = !valid_o || ready_i;
  assign busy_o    = (state == GRANT) || valid_o;

  // full/alm_full only matter to a writer; this block never pushes
  always_comb begin
    unused_resp = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      avail[i]    = !fifo_resp_i[i].empty && !flush_i[i];
      unused_resp = unused_resp ^ fifo_resp_i[i].full ^ fifo_resp_i[i].alm_full;
    end
  end

  // first available channel at or after rr_ptr, wrapping at N_CH
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
      if (!found && avail[sum[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_ch_nxt   = gnt_ch;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    pop_any      = 1'b0;
    case (state)
      IDLE: begin
        if (en_i && found) begin
          gnt_ch_nxt   = pick;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        pop_any = en_i && !flush_i[gnt_ch] && !fifo_resp_i[gnt_ch].empty && slot_free;
        if (pop_any) beat_cnt_nxt = beat_cnt + 8'd1;
        if ((pop_any && beat_cnt_nxt == 8'(BURST_LEN)) ||
            (fifo_resp_i[gnt_ch].empty && slot_free) ||
            flush_i[gnt_ch] || !en_i) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (gnt_ch == CH_W'(N_CH-1)) ? '0 : gnt_ch + CH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      fifo_req_o[i].pop   = pop_any && (gnt_ch == CH_W'(i));
      fifo_req_o[i].push  = 1'b0;
      fifo_req_o[i].flush = flush_i[i];
      fifo_req_o[i].data  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      gnt_ch   <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
      ch_o     <= '0;
    end else begin
      state    <= state_nxt;
      gnt_ch   <= gnt_ch_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (pop_any) begin
        valid_o <= 1'b1;
        data_o  <= fifo_resp_i[gnt_ch].data;
        ch_o    <= gnt_ch;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
